// File: rtl/complex_row_vector_chunk_streamer.sv
// Streams one matrix row and the matching vector slice per chunk of no_of_units complex lanes,
// fetching from two one-cycle-latency memories and zero-padding the tail lanes of a short final chunk.
module complex_row_vector_chunk_streamer #(
  parameter int number_of_equations_per_cluster = 16,
  parameter int element_width                   = 64,
  parameter int no_of_units                     = 8,
  parameter int chunks_per_row = (number_of_equations_per_cluster + no_of_units - 1) / no_of_units,
  parameter int addr_width                      = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 consumer_ready,
  output logic [addr_width-1:0]                row_mem_addr,
  input  logic [element_width*no_of_units-1:0] row_mem_data,
  output logic [addr_width-1:0]                vec_mem_addr,
  input  logic [element_width*no_of_units-1:0] vec_mem_data,
  output logic [element_width*no_of_units-1:0] first_row_plus_additional,
  output logic [element_width*no_of_units-1:0] vector2,
  output logic                                 outsider_read_now,
  output logic                                 last_chunk_of_row,
  output logic [15:0]                          row_index,
  output logic                                 busy,
  output logic                                 done
);

  localparam int n_eq      = number_of_equations_per_cluster;
  localparam int bus_w     = element_width * no_of_units;
  localparam int rem_lanes = n_eq % no_of_units;
  localparam bit has_pad   = (rem_lanes != 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [15:0]           row_q, row_nxt;
  logic [15:0]           chunk_q, chunk_nxt;
  logic [15:0]           row_index_q;
  logic                  is_last_chunk;
  logic                  is_last_row;
  logic [addr_width-1:0] row_addr_nxt;
  logic [addr_width-1:0] vec_addr_nxt;
  logic [bus_w-1:0]      row_masked;
  logic [bus_w-1:0]      vec_masked;

  assign is_last_chunk = (chunk_q == 16'(chunks_per_row - 1));
  assign is_last_row   = (row_q == 16'(n_eq - 1));

  // Handshake: a chunk is offered while outsider_read_now is high and is taken on any
  // rising edge where consumer_ready is also high; until then data and addresses hold.
  always_comb begin
    state_nxt = state;
    row_nxt   = row_q;
    chunk_nxt = chunk_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
          row_nxt   = '0;
          chunk_nxt = '0;
        end
      end
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_PRESENT;
      S_PRESENT: begin
        if (consumer_ready) begin
          if (is_last_chunk) begin
            chunk_nxt = '0;
            row_nxt   = row_q + 16'd1;
          end else begin
            chunk_nxt = chunk_q + 16'd1;
          end
          state_nxt = (is_last_row && is_last_chunk) ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Addresses are computed from the counters the next FETCH will use, so they are
  // stable for the whole FETCH/WAIT/PRESENT span of a chunk.
  always_comb begin
    row_addr_nxt = addr_width'(32'(row_nxt) * 32'(chunks_per_row) + 32'(chunk_nxt));
    vec_addr_nxt = addr_width'(32'(chunk_nxt));
  end

  // Lanes beyond the equation count in the final chunk of a row carry no data.
  always_comb begin
    row_masked = row_mem_data;
    vec_masked = vec_mem_data;
    for (int k = 0; k < no_of_units; k++) begin
      if (has_pad && is_last_chunk && (k >= rem_lanes)) begin
        row_masked[k*element_width +: element_width] = '0;
        vec_masked[k*element_width +: element_width] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                     <= S_IDLE;
      row_q                     <= '0;
      chunk_q                   <= '0;
      row_index_q               <= '0;
      row_mem_addr              <= '0;
      vec_mem_addr              <= '0;
      first_row_plus_additional <= '0;
      vector2                   <= '0;
    end else begin
      state   <= state_nxt;
      row_q   <= row_nxt;
      chunk_q <= chunk_nxt;
      if (state_nxt == S_FETCH) begin
        row_mem_addr <= row_addr_nxt;
        vec_mem_addr <= vec_addr_nxt;
      end
      if (state == S_WAIT) begin
        first_row_plus_additional <= row_masked;
        vector2                   <= vec_masked;
        row_index_q               <= row_q;
      end
    end
  end

  assign outsider_read_now = (state == S_PRESENT);
  assign last_chunk_of_row = (state == S_PRESENT) && is_last_chunk;
  assign row_index         = row_index_q;
  assign busy              = (state == S_FETCH) || (state == S_WAIT) || (state == S_PRESENT);
  assign done              = (state == S_DONE);

endmodule

// File: doc/complex_row_vector_chunk_streamer.md
Name: complex_row_vector_chunk_streamer

Overview:
Source-side streamer for the complex matrix-by-vector dot-product path. It reads one matrix row at a time from row memory and the matching vector slice from vector memory, in chunks of no_of_units complex elements. Each chunk is presented as first_row_plus_additional / vector2 with outsider_read_now as its valid strobe. When the last chunk of a row lands past the equation count, its unused lanes are zero-padded. The block feeds the row-times-vector control unit and its eight-lane complex dot-product engine.

Parameters:
number_of_equations_per_cluster, 16, N: matrix dimension (rows and columns).
element_width, 64, width of one complex element (32-bit real in the upper half, 32-bit imaginary in the lower half).
no_of_units, 8, lanes per chunk.
chunks_per_row, (N+no_of_units-1)/no_of_units, derived; chunks per row.
addr_width, 16, memory address width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-low reset.
start  in  1  one-cycle pulse; begins a full matrix pass when idle.
consumer_ready  in  1  consumer accepts the presented chunk this cycle.
row_mem_addr  out  addr_width  row-memory chunk address.
row_mem_data  in  element_width*no_of_units  row-memory read data, one-cycle latency.
vec_mem_addr  out  addr_width  vector-memory chunk address.
vec_mem_data  in  element_width*no_of_units  vector-memory read data, one-cycle latency.
first_row_plus_additional  out  element_width*no_of_units  matrix chunk; lane k at bits [k*element_width +: element_width].
vector2  out  element_width*no_of_units  vector chunk, same lane layout.
outsider_read_now  out  1  chunk valid.
last_chunk_of_row  out  1  qualifies outsider_read_now; the presented chunk ends its row.
row_index  out  16  row of the presented chunk.
busy  out  1  high from accepted start until done.
done  out  1  one-cycle pulse after the final chunk is accepted.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE.
  - All outputs 0: addresses, data buses, outsider_read_now, last_chunk_of_row, row_index, busy, done.
  - Internal row/chunk counters cleared.
  - Reset mid-pass aborts immediately; no done pulse.
- FSM states: IDLE, FETCH, WAIT, PRESENT, DONE.
- IDLE:
  - start=1 -> FETCH; busy=1 from the next cycle.
  - Row and chunk counters set to 0.
- FETCH:
  - Drive row_mem_addr = row*chunks_per_row + chunk and vec_mem_addr = chunk.
  - -> WAIT.
- WAIT:
  - Memory data valid at the end of this cycle; register it into the output buses.
  - Padding: if chunk==chunks_per_row-1 and N%no_of_units != 0, lanes k >= N%no_of_units are forced to 0 on both buses.
  - -> PRESENT.
- PRESENT:
  - outsider_read_now=1.
  - last_chunk_of_row=(chunk==chunks_per_row-1).
  - row_index=row.
  - Data held stable while consumer_ready=0 (unbounded stall).
  - On consumer_ready=1, the chunk is accepted that cycle and outsider_read_now drops next cycle.
  - Counter advance: chunk increments; at row end, chunk wraps to 0 and row increments.
  - If row==N-1 and chunk==chunks_per_row-1 -> DONE; else -> FETCH.
- DONE:
  - done=1 for exactly one cycle, busy=0 at the same edge.
  - -> IDLE.
- start while busy: ignored.
- start and reset low in the same cycle: reset wins.
- Latency:
  - First outsider_read_now is asserted 3 cycles after the start edge.
  - Peak throughput is one chunk per 3 cycles with consumer_ready held high.
  - A full pass with consumer_ready=1 takes 3*N*chunks_per_row cycles, plus 1 cycle of DONE.
- Address arithmetic is unsigned and truncates to addr_width. N*chunks_per_row must be <= 2^addr_width; this is not checked in RTL.
- Output buses retain their last value outside PRESENT; consumers qualify with outsider_read_now.

Test Plan:
1. Reset/idle: reset=0 for 2 cycles, then 1; hold start=0 -> all outputs 0; busy=0; no memory address change.
2. N=16, units=8, consumer_ready=1, memories preloaded with address-tagged data:
   - start -> 32 chunks, first valid 3 cycles after start.
   - row_mem_addr sequence 0..31; vec_mem_addr alternates 0,1.
   - last_chunk_of_row on every 2nd chunk; row_index 0..15.
   - done one cycle after the 32nd accept, 97 cycles after start.
3. Padding, N=12, units=8:
   - Chunk 1 of each row has lanes 4..7 = 0 on both buses; lanes 0..3 match memory.
   - 24 chunks total.
4. Backpressure:
   - consumer_ready low for 5 cycles during chunk 3 -> outsider_read_now and both buses stable for all 5 cycles; no address advance.
   - The chunk is accepted on the first ready cycle.
   - Chunk count is unchanged; done is delayed by 5 cycles.
5. start pulsed again mid-pass (chunk 10) -> ignored; sequence and done timing identical to scenario 2.
6. Reset low during chunk 20, then a fresh start:
   - Outputs cleared the next cycle; no done pulse.
   - The new pass restarts at row 0, chunk 0 with full 32-chunk output.
